div: RTL and testbench

Sequential restoring (shift-subtract) unsigned divider. It is the inverse counterpart of the team's shift-add multiplier and uses the same datapath/controller split and start/ready handshake. It accepts a WIDTH-bit dividend and divisor on `start`, runs one shift cycle and one subtract cycle per quotient bit, then presents the quotient and remainder with `ready` high. It sits beside the multiplier in the small-ALU test design.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_datapath.sv | 57 +++++
 rtl/div.sv | 108 ++++++++++
 tb/tb_div.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring shift-subtract divider:
// state encoding and default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SUB   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_SUB   = S_SUB
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: partial remainder, dividend/quotient and divisor registers
// with the trial subtractor, driven by load/shift/sub strobes from the controller.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_dz,
  input  logic             shift,
  input  logic             sub,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   diff;
  logic             diff_neg;

  // A borrow out of the top bit means the divisor did not fit.
  assign diff     = rem_r - {1'b0, dsr_r};
  assign diff_neg = diff[WIDTH];

  // Operand capture, shift and conditional restore of the partial remainder.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_r <= '0;
      quo_r <= '0;
      dsr_r <= '0;
    end else if (load) begin
      rem_r <= '0;
      quo_r <= dividend;
      dsr_r <= divisor;
    end else if (load_dz) begin
      rem_r <= {1'b0, dividend};
      quo_r <= '1;
    end else if (shift) begin
      {rem_r, quo_r} <= {rem_r[WIDTH-1:0], quo_r, 1'b0};
    end else if (sub && !diff_neg) begin
      rem_r    <= diff;
      quo_r[0] <= 1'b1;
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Sequential restoring unsigned divider: controller FSM and iteration counter
// around div_datapath, with a start/ready handshake.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          dz_r;
  logic          load;
  logic          load_dz;
  logic          shift;
  logic          sub;

  // Next-state and strobe decode; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_dz    = 1'b0;
    shift      = 1'b0;
    sub        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            load       = 1'b1;
            next_state = ST_SHIFT;
          end else begin
            load_dz    = 1'b1;
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift      = 1'b1;
        next_state = ST_SUB;
      end
      ST_SUB: begin
        sub = 1'b1;
        if (cnt == CW'(WIDTH)) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_SHIFT;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, iteration counter and divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dz_r  <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        cnt  <= '0;
        dz_r <= 1'b0;
      end else if (load_dz) begin
        dz_r <= 1'b1;
      end else if (shift) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt  <= cnt;
        dz_r <= dz_r;
      end
    end
  end

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_dz   (load_dz),
    .shift     (shift),
    .sub       (sub),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign div_zero = dz_r;
  // Held low while reset is asserted so no spurious handshake is seen.
  assign ready    = (state == ST_IDLE) & reset;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (WIDTH=4): table-driven operations through a
// scoreboard queue, plus hand-written reset, busy, and back-to-back sequences.
module tb_div;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;
  logic       ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  div #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_div_zero"}, div_zero, e.dz);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the result edge.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic edz);
    exp_t e;
    int   n;
    e.q = eq; e.r = er; e.dz = edz;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    if (b == 4'd0) begin
      chk("dz_ready_held", ready, 1'b1);
    end else begin
      chk("busy_after_start", ready, 1'b0);
      while (!ready && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("latency", n, (b == 4'd0) ? 32'd1 : 32'd9);
    check_result("op");
  endtask

  initial begin
    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dz: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
    vecs[6] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0};
    vecs[7] = '{a: 4'd10, b: 4'd3,  q: 4'd3,  r: 4'd1, dz: 1'b0};

    reset = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;

    // Reset held low two cycles, then release.
    @(posedge clk);
    #1 chk("rst_ready_low0", ready, 1'b0);
    @(posedge clk);
    #1 chk("rst_ready_low1", ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel_ready", ready, 1'b1);
    chk("rel_quotient", quotient, 4'd0);
    chk("rel_remainder", remainder, 4'd0);
    chk("rel_div_zero", div_zero, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Busy: start pulsed with new operands during the run must be ignored.
    begin
      exp_t e;
      int   n;
      e.q = 4'd4; e.r = 4'd2; e.dz = 1'b0;
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 dividend = 4'd1; divisor = 4'd1;
      n = 1;
      repeat (5) begin
        @(posedge clk);
        #1;
        n++;
      end
      start = 1'b0;
      while (!ready && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("busy_latency", n, 32'd9);
      check_result("busy");
    end

    // Reset asserted at edge 4 of a 13 / 4 run.
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_quotient", quotient, 4'd0);
    chk("midrst_remainder", remainder, 4'd0);
    chk("midrst_div_zero", div_zero, 1'b0);
    reset = 1'b1;
    #1 chk("midrst_rel_ready", ready, 1'b1);
    @(posedge clk);
    #1 chk("midrst_idle_outputs", quotient, 4'd0);
    do_op(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);

    // Back-to-back with start held high: 12 / 5 then 7 / 2.
    begin
      exp_t e;
      e.q = 4'd2; e.r = 4'd2; e.dz = 1'b0;
      sb.push_back(e);
      e.q = 4'd3; e.r = 4'd1;
      sb.push_back(e);
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      @(posedge clk);
      repeat (7) begin
        @(posedge clk);
        #1 chk("b2b_busy1", ready, 1'b0);
      end
      @(posedge clk);
      #1 chk("b2b_ready8", ready, 1'b1);
      check_result("b2b_first");
      dividend = 4'd7; divisor = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b_busy9", ready, 1'b0);
      repeat (7) @(posedge clk);
      #1 chk("b2b_busy16", ready, 1'b0);
      @(posedge clk);
      #1 chk("b2b_ready17", ready, 1'b1);
      check_result("b2b_second");
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
